// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Read-side drain of async_fifo_16x16 into a valid/ready stream,
//            with a 2-entry skid buffer and m_last framing every FRAME_LEN words.
//            Optional stall counter output enabled by FIFO_RD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_cnt
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(FRAME_LEN - 1);

    // Encoding equals the number of occupied skid entries.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_state_t;

    occ_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic                  inflight_q, inflight_d;

    logic [1:0]            w_occ;
    logic [2:0]            w_level;
    logic                  w_pop;
    logic                  w_unused_status;

    assign w_unused_status = fifo_almost_empty;

    assign w_occ   = state_q;
    assign m_valid = (state_q != S_EMPTY);
    assign w_pop   = m_valid && m_ready;
    assign w_level = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};

    // Read only when the returning word is guaranteed a free skid slot.
    assign fifo_rd_en = rd_reset_n && !fifo_empty && !flush && (w_level < 3'd2);

    assign m_data   = head_q;
    assign word_cnt = word_cnt_q;
    assign m_last   = m_valid && (word_cnt_q == c_LAST);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        word_cnt_d = word_cnt_q;
        inflight_d = fifo_rd_en && !fifo_empty;
        if (flush) begin
            state_d    = S_EMPTY;
            head_d     = '0;
            tail_d     = '0;
            word_cnt_d = '0;
            inflight_d = 1'b0;
        end else begin
            if (w_pop) begin
                word_cnt_d = (word_cnt_q == c_LAST) ? '0 : word_cnt_q + CNT_WIDTH'(1);
            end
            case (state_q)
                S_EMPTY: begin
                    if (inflight_q) begin
                        head_d  = fifo_rd_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    case ({inflight_q, w_pop})
                        2'b11: head_d = fifo_rd_data;
                        2'b10: begin
                            tail_d  = fifo_rd_data;
                            state_d = S_FULL;
                        end
                        2'b01: begin
                            head_d  = '0;
                            state_d = S_EMPTY;
                        end
                        default: ;
                    endcase
                end
                S_FULL: begin
                    if (w_pop) begin
                        head_d  = tail_q;
                        tail_d  = '0;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_reset_n) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            word_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            word_cnt_q <= word_cnt_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Directed self-checking bench for fifo_rd_stream with a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int FRAME_LEN = 8;

    logic        rd_clk = 1'b0;
    logic        rd_reset_n;
    logic        fifo_empty;
    logic        fifo_almost_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic [15:0] word_cnt;
`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(
        .DATA_WIDTH (16),
        .FRAME_LEN  (FRAME_LEN),
        .CNT_WIDTH  (16)
    ) dut (
        .rd_clk            (rd_clk),
        .rd_reset_n        (rd_reset_n),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .flush             (flush),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_last            (m_last),
        .word_cnt          (word_cnt)
`ifdef FIFO_RD_STALL_CNT_EN
        ,
        .stall_cnt         (stall_cnt)
`endif
    );

    // Read-port model: one-cycle data latency, empty may be held high longer.
    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty = 1'b0;

    assign fifo_empty        = (wr_ptr == rd_ptr) || force_empty;
    assign fifo_almost_empty = ((wr_ptr - rd_ptr) <= 1);

    always @(posedge rd_clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int viol_rd   = 0;
    int viol_full = 0;
    always @(negedge rd_clk) begin
        if (fifo_rd_en && fifo_empty) viol_rd++;
        if (dut.inflight_q && (dut.state_q == 2'd2)) viol_full++;
    end

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    task automatic load(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            mem[8'(wr_ptr + i)] = base + 16'(i);
        end
        wr_ptr = wr_ptr + n;
    endtask

    task automatic test_reset;
        rd_reset_n = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        load(2, 16'hDEAD);
        repeat (3) @(negedge rd_clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_last); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        rd_ptr     = wr_ptr;
        rd_reset_n = 1'b1;
        @(negedge rd_clk);
    endtask

    task automatic test_stream;
        int idx = 0, first_en = -1, first_v = -1, last_v = -1, got = 0, lasts = 0;
        logic [15:0] ew;
        m_ready = 1'b1;
        load(16, 16'h0001);
        #1;
        while (got < 16 && idx < 60) begin
            if (first_en < 0 && fifo_rd_en) first_en = idx;
            if (m_valid) begin
                if (first_v < 0) first_v = idx;
                last_v = idx;
                ew = 16'(got + 1);
                if (m_last) lasts++;
                checks++;
                if (m_data !== ew || m_last !== (exp_cnt == FRAME_LEN - 1) || word_cnt !== 16'(exp_cnt)) begin
                    errors++;
                    $display("FAIL stream_word: got data=%h last=%b cnt=%0d want data=%h last=%b cnt=%0d",
                             m_data, m_last, word_cnt, ew, (exp_cnt == FRAME_LEN - 1), exp_cnt);
                end
                exp_cnt = (exp_cnt + 1) % FRAME_LEN;
                got++;
            end
            @(negedge rd_clk);
            idx++;
        end
        checks++; if (got != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", got); end
        checks++; if (first_en != 0 || first_v != 2) begin errors++; $display("FAIL stream_latency: got en@%0d valid@%0d want en@0 valid@2", first_en, first_v); end
        checks++; if (last_v - first_v != 15) begin errors++; $display("FAIL stream_gapless: got span %0d want 15", last_v - first_v); end
        checks++; if (lasts != 2) begin errors++; $display("FAIL stream_lasts: got %0d want 2", lasts); end
        checks++; if (word_cnt !== 16'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got cnt=%0d valid=%b want 0 0", word_cnt, m_valid); end
    endtask

    task automatic test_backpressure;
        int start, bad_early = 0, unstable = 0, got = 0;
        m_ready     = 1'b0;
        force_empty = 1'b1;
        load(4, 16'h0001);
        repeat (3) begin
            @(negedge rd_clk);
            if (fifo_rd_en !== 1'b0) bad_early++;
        end
        checks++; if (bad_early != 0) begin errors++; $display("FAIL bp_empty_delay: got %0d reads want 0", bad_early); end
        start       = rd_ptr;
        force_empty = 1'b0;
        repeat (10) begin
            @(negedge rd_clk);
            if (m_valid && (m_data !== 16'h0001 || word_cnt !== 16'(exp_cnt) || m_last !== 1'b0)) unstable++;
        end
        checks++; if (rd_ptr - start != 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", rd_ptr - start); end
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin errors++; $display("FAIL bp_hold: got valid=%b data=%h want 1 0001", m_valid, m_data); end
        checks++; if (dut.state_q !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d want 2", dut.state_q); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        m_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== 16'(got + 1) || word_cnt !== 16'(exp_cnt)) begin
                    errors++;
                    $display("FAIL bp_word: got data=%h cnt=%0d want data=%h cnt=%0d", m_data, word_cnt, 16'(got + 1), exp_cnt);
                end
                exp_cnt = (exp_cnt + 1) % FRAME_LEN;
                got++;
            end
            @(negedge rd_clk);
        end
        checks++; if (got != 4 || m_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0d words valid=%b want 4 0", got, m_valid); end
    endtask

    task automatic test_toggle;
        int got = 0;
        logic [15:0] ew;
        m_ready = 1'b0;
        load(32, 16'h0100);
        for (int c = 0; c < 200 && got < 32; c++) begin
            m_ready = ~m_ready;
            if (m_valid && m_ready) begin
                ew = 16'h0100 + 16'(got);
                checks++;
                if (m_data !== ew || m_last !== (exp_cnt == FRAME_LEN - 1) || word_cnt !== 16'(exp_cnt)) begin
                    errors++;
                    $display("FAIL toggle_word: got data=%h last=%b cnt=%0d want data=%h cnt=%0d",
                             m_data, m_last, word_cnt, ew, exp_cnt);
                end
                exp_cnt = (exp_cnt + 1) % FRAME_LEN;
                got++;
            end
            @(negedge rd_clk);
        end
        checks++; if (got != 32) begin errors++; $display("FAIL toggle_count: got %0d want 32", got); end
        checks++; if (viol_rd != 0) begin errors++; $display("FAIL toggle_rd_empty: got %0d want 0", viol_rd); end
        checks++; if (viol_full != 0) begin errors++; $display("FAIL toggle_write_full: got %0d want 0", viol_full); end
    endtask

    task automatic test_flush;
        int got = 0;
        m_ready = 1'b0;
        load(5, 16'h0200);
        @(negedge rd_clk);
        @(negedge rd_clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0200) begin errors++; $display("FAIL flush_pre: got valid=%b data=%h want 1 0200", m_valid, m_data); end
        flush = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en); end
        @(negedge rd_clk);
        checks++; if (m_valid !== 1'b0 || word_cnt !== 16'd0 || m_data !== 16'h0) begin errors++; $display("FAIL flush_clear: got valid=%b cnt=%0d data=%h want 0 0 0000", m_valid, word_cnt, m_data); end
        flush   = 1'b0;
        exp_cnt = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== 16'h0202 + 16'(got) || word_cnt !== 16'(exp_cnt)) begin
                    errors++;
                    $display("FAIL flush_resume: got data=%h cnt=%0d want data=%h cnt=%0d", m_data, word_cnt, 16'h0202 + 16'(got), exp_cnt);
                end
                exp_cnt = (exp_cnt + 1) % FRAME_LEN;
                got++;
            end
            @(negedge rd_clk);
        end
        checks++; if (got != 3 || m_valid !== 1'b0) begin errors++; $display("FAIL flush_drain: got %0d valid=%b want 3 0", got, m_valid); end
    endtask

    task automatic test_reset_mid;
        int got = 0, base, k, total;
        flush = 1'b1;
        @(negedge rd_clk);
        flush   = 1'b0;
        exp_cnt = 0;
        base    = wr_ptr;
        m_ready = 1'b1;
        load(10, 16'h0300);
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== 16'h0300 + 16'(got) || word_cnt !== 16'(got)) begin
                    errors++;
                    $display("FAIL rst_mid_word: got data=%h cnt=%0d want data=%h cnt=%0d", m_data, word_cnt, 16'h0300 + 16'(got), got);
                end
                got++;
                if (got == 5) begin
                    @(posedge rd_clk);
                    #1 m_ready = 1'b0;
                end
            end
            @(negedge rd_clk);
        end
        checks++; if (word_cnt !== 16'd5 || m_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pos: got cnt=%0d valid=%b want 5 1", word_cnt, m_valid); end
        rd_reset_n = 1'b0;
        @(negedge rd_clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0000", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_mid_last: got %b want 0", m_last); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", word_cnt); end
        rd_reset_n = 1'b1;
        m_ready    = 1'b1;
        k          = rd_ptr - base;
        total      = wr_ptr - rd_ptr;
        got        = 0;
        exp_cnt    = 0;
        for (int c = 0; c < 40 && got < total; c++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== 16'h0300 + 16'(k + got) || word_cnt !== 16'(exp_cnt)) begin
                    errors++;
                    $display("FAIL rst_mid_resume: got data=%h cnt=%0d want data=%h cnt=%0d", m_data, word_cnt, 16'h0300 + 16'(k + got), exp_cnt);
                end
                exp_cnt = (exp_cnt + 1) % FRAME_LEN;
                got++;
            end
            @(negedge rd_clk);
        end
        checks++; if (got != total || total == 0) begin errors++; $display("FAIL rst_mid_drain: got %0d of %0d want all (nonzero)", got, total); end
    endtask

`ifdef FIFO_RD_STALL_CNT_EN
    task automatic test_stall;
        m_ready = 1'b0;
        load(1, 16'hABCD);
        repeat (4) @(negedge rd_clk);
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_early: got %0d want 2", stall_cnt); end
        repeat (70000) @(negedge rd_clk);
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h want ffff", stall_cnt); end
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        checks++; if (stall_cnt !== 16'h0 || m_valid !== 1'b0) begin errors++; $display("FAIL stall_flush: got cnt=%h valid=%b want 0000 0", stall_cnt, m_valid); end
    endtask
`endif

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_toggle;
        test_flush;
        test_reset_mid;
`ifdef FIFO_RD_STALL_CNT_EN
        test_stall;
`endif
        checks++; if (viol_rd != 0 || viol_full != 0) begin errors++; $display("FAIL final_monitors: got rd_empty=%0d write_full=%0d want 0 0", viol_rd, viol_full); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
